// File: rtl/console_cmd_rx_if.sv
// Byte-stream input and fs_read/fd_read command handshake bundle for console_cmd_rx.
// slave is the receiver's view; master is the driving side (link receiver plus console controller).
interface console_cmd_rx_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       fs_read;
    logic       fd_read;
    logic [1:0] com_state;
    logic [7:0] err_cnt;
    logic       busy;

    modport slave (
        input  rx_data, rx_valid, fd_read,
        output fs_read, com_state, err_cnt, busy
    );

    modport master (
        output rx_data, rx_valid, fd_read,
        input  fs_read, com_state, err_cnt, busy
    );
endinterface

// File: rtl/console_cmd_rx.sv
// Parses HDR0,HDR1,CMD,CHK frames into a one-deep pending slot and hands commands over fs_read/fd_read.
// Define CMD_FILTER_SAME_EN to swallow a repeated SAME command instead of re-delivering it.
module console_cmd_rx #(
    parameter logic [7:0]  HDR0    = 8'h55,
    parameter logic [7:0]  HDR1    = 8'hAA,
    parameter logic [15:0] TIMEOUT = 16'd50000
) (
    input  logic            clk,
    input  logic            rst_n,
    console_cmd_rx_if.slave cmd_bus
);
    typedef enum logic [1:0] {P_HUNT, P_HDR1, P_CMD, P_CHK} pstate_t;
    typedef enum logic [1:0] {H_IDLE, H_REQ, H_REL} hstate_t;

    pstate_t     r_pstate, w_pstate_nxt;
    hstate_t     r_hstate, w_hstate_nxt;
    logic [15:0] r_idle, w_idle_nxt;
    logic [7:0]  r_cmd, w_cmd_nxt;
    logic        r_slot_full, w_slot_full_nxt;
    logic [1:0]  r_slot_cmd, w_slot_cmd_nxt;
    logic [1:0]  r_com_state, w_com_nxt;
    logic [7:0]  r_err_cnt, w_err_nxt;

    logic w_take, w_frame_end, w_frame_good, w_frame_skip;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // The slot is freed in the same cycle a new frame may land in it, so a full
    // slot only causes a drop when the handshake is not taking it this cycle.
    assign w_take       = (r_hstate == H_IDLE) && r_slot_full;
    assign w_frame_end  = cmd_bus.rx_valid && (r_pstate == P_CHK);
    assign w_frame_good = (cmd_bus.rx_data == ~r_cmd) && (r_cmd[7:2] == 6'd0);
`ifdef CMD_FILTER_SAME_EN
    assign w_frame_skip = (r_cmd[1:0] == 2'b11) && (r_com_state == 2'b11);
`else
    assign w_frame_skip = 1'b0;
`endif

    always_comb begin
        w_pstate_nxt = r_pstate;
        w_idle_nxt   = r_idle;
        w_cmd_nxt    = r_cmd;
        if (cmd_bus.rx_valid) begin
            w_idle_nxt = '0;
            unique case (r_pstate)
                P_HUNT: if (cmd_bus.rx_data == HDR0) w_pstate_nxt = P_HDR1;
                P_HDR1: begin
                    if (cmd_bus.rx_data == HDR1)      w_pstate_nxt = P_CMD;
                    else if (cmd_bus.rx_data != HDR0) w_pstate_nxt = P_HUNT;
                end
                P_CMD: begin
                    w_cmd_nxt    = cmd_bus.rx_data;
                    w_pstate_nxt = P_CHK;
                end
                P_CHK:   w_pstate_nxt = P_HUNT;
                default: w_pstate_nxt = P_HUNT;
            endcase
        end else if (r_pstate != P_HUNT) begin
            if (r_idle >= TIMEOUT) begin
                w_pstate_nxt = P_HUNT;
                w_idle_nxt   = '0;
            end else begin
                w_idle_nxt = r_idle + 16'd1;
            end
        end
    end

    always_comb begin
        w_slot_full_nxt = r_slot_full;
        w_slot_cmd_nxt  = r_slot_cmd;
        w_err_nxt       = r_err_cnt;
        w_hstate_nxt    = r_hstate;
        w_com_nxt       = r_com_state;
        if (w_take) w_slot_full_nxt = 1'b0;
        if (w_frame_end) begin
            if (!w_frame_good) begin
                w_err_nxt = sat_inc(r_err_cnt);
            end else if (!w_frame_skip) begin
                if (r_slot_full && !w_take) begin
                    w_err_nxt = sat_inc(r_err_cnt);
                end else begin
                    w_slot_full_nxt = 1'b1;
                    w_slot_cmd_nxt  = r_cmd[1:0];
                end
            end
        end
        case (r_hstate)
            H_IDLE: if (r_slot_full) begin
                w_com_nxt    = r_slot_cmd;
                w_hstate_nxt = H_REQ;
            end
            H_REQ:   if (cmd_bus.fd_read)  w_hstate_nxt = H_REL;
            H_REL:   if (!cmd_bus.fd_read) w_hstate_nxt = H_IDLE;
            default: w_hstate_nxt = H_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pstate    <= P_HUNT;
            r_hstate    <= H_IDLE;
            r_idle      <= '0;
            r_slot_full <= 1'b0;
            r_com_state <= 2'b00;
            r_err_cnt   <= '0;
        end else begin
            r_pstate    <= w_pstate_nxt;
            r_hstate    <= w_hstate_nxt;
            r_idle      <= w_idle_nxt;
            r_slot_full <= w_slot_full_nxt;
            r_com_state <= w_com_nxt;
            r_err_cnt   <= w_err_nxt;
        end
    end

    // Frame payload registers are only read while their qualifying state is active.
    always_ff @(posedge clk) begin
        r_cmd      <= w_cmd_nxt;
        r_slot_cmd <= w_slot_cmd_nxt;
    end

    assign cmd_bus.fs_read   = (r_hstate == H_REQ);
    assign cmd_bus.com_state = r_com_state;
    assign cmd_bus.err_cnt   = r_err_cnt;
    assign cmd_bus.busy      = (r_pstate != P_HUNT) || r_slot_full || (r_hstate != H_IDLE);
endmodule

// File: tb/tb_console_cmd_rx.sv
// Directed and randomized checks of console_cmd_rx against a frame-level reference model.
module tb_console_cmd_rx;
    localparam int TO = 40;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    console_cmd_rx_if bus();

    console_cmd_rx #(.HDR0(8'h55), .HDR1(8'hAA), .TIMEOUT(16'(TO))) dut (
        .clk(clk), .rst_n(rst_n), .cmd_bus(bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic auto_ack = 1'b0;
    logic auto_fd  = 1'b0;
    logic man_fd   = 1'b0;
    assign bus.fd_read = auto_ack ? auto_fd : man_fd;

    logic [1:0] exp_q[$];
    logic [1:0] last_dlv = 2'b00;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        step();
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [7:0] k);
        send_byte(8'h55);
        send_byte(8'hAA);
        send_byte(c);
        send_byte(k);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        step();
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (bus.busy && k < 300) begin
            step();
            k++;
        end
        chk(tag, int'(bus.busy), 0);
    endtask

    // Delivery monitor: every new request must carry the next command the model expects.
    initial begin : dlv_mon
        logic prev_fs;
        prev_fs = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (auto_ack && bus.fs_read && !prev_fs) begin
                if (exp_q.size() == 0) begin
                    chk("dlv_unexpected", 1, 0);
                end else begin
                    last_dlv = exp_q.pop_front();
                    chk("dlv_cmd", int'(bus.com_state), int'(last_dlv));
                end
            end else if (auto_ack && bus.fs_read) begin
                chk("dlv_hold", int'(bus.com_state), int'(last_dlv));
            end
            prev_fs = bus.fs_read;
        end
    end

    // Randomly delayed four-phase acknowledge used during the random phase.
    initial begin : ack_proc
        forever begin
            @(posedge clk);
            #2;
            if (auto_ack && bus.fs_read) begin
                repeat ($urandom_range(0, 4)) @(posedge clk);
                #2 auto_fd = 1'b1;
                for (int k = 0; k < 20 && bus.fs_read; k++) begin
                    @(posedge clk);
                    #2;
                end
                if (bus.fs_read) chk("ack_timeout", 1, 0);
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #2 auto_fd = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got running expected finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int         viol, nn, kind, exp_err;
        logic [7:0] b, cmd, ck;
        logic [1:0] model_com;
        logic       good, skip;

        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        #2 rst_n = 1'b0;
        idle(2);
        chk("rst_fs_read", int'(bus.fs_read), 0);
        chk("rst_com_state", int'(bus.com_state), 0);
        chk("rst_err_cnt", int'(bus.err_cnt), 0);
        chk("rst_busy", int'(bus.busy), 0);
        rst_n = 1'b1;
        step();

        // Basic delivery and latency
        send_frame(8'h01, 8'hFE);
        chk("t1_fs_n1", int'(bus.fs_read), 0);
        step();
        chk("t1_fs_n2", int'(bus.fs_read), 1);
        chk("t1_com", int'(bus.com_state), 1);
        step();
        man_fd = 1'b1;
        chk("t1_fs_before_ack", int'(bus.fs_read), 1);
        step();
        chk("t1_fs_after_ack", int'(bus.fs_read), 0);
        chk("t1_busy_rel", int'(bus.busy), 1);
        man_fd = 1'b0;
        idle(2);
        chk("t1_busy_end", int'(bus.busy), 0);
        chk("t1_err", int'(bus.err_cnt), 0);
        chk("t1_com_held", int'(bus.com_state), 1);

        // Request holds while the controller is slow
        send_frame(8'h02, 8'hFD);
        idle(1);
        viol = 0;
        for (int i = 0; i < 100; i++) begin
            if (!bus.fs_read || bus.com_state != 2'b10) viol++;
            step();
        end
        chk("t2_hold_viol", viol, 0);
        man_fd = 1'b1;
        step();
        chk("t2_fs_drop", int'(bus.fs_read), 0);
        man_fd = 1'b0;
        idle(2);
        chk("t2_busy_end", int'(bus.busy), 0);
        chk("t2_com", int'(bus.com_state), 2);

        // Bad checksum and bad code
        send_frame(8'h02, 8'h00);
        idle(3);
        chk("t3_fs_badchk", int'(bus.fs_read), 0);
        chk("t3_err1", int'(bus.err_cnt), 1);
        send_frame(8'h06, 8'hF9);
        idle(3);
        chk("t3_fs_badcode", int'(bus.fs_read), 0);
        chk("t3_err2", int'(bus.err_cnt), 2);
        chk("t3_busy", int'(bus.busy), 0);

        // Pending slot and drop
        do_reset();
        send_frame(8'h01, 8'hFE);
        send_frame(8'h02, 8'hFD);
        send_frame(8'h03, 8'hFC);
        idle(2);
        chk("t4_err_drop", int'(bus.err_cnt), 1);
        chk("t4_fs_first", int'(bus.fs_read), 1);
        chk("t4_com_first", int'(bus.com_state), 1);
        man_fd = 1'b1;
        step();
        chk("t4_fs_rel1", int'(bus.fs_read), 0);
        chk("t4_com_rel1", int'(bus.com_state), 1);
        man_fd = 1'b0;
        idle(2);
        chk("t4_fs_second", int'(bus.fs_read), 1);
        chk("t4_com_second", int'(bus.com_state), 2);
        man_fd = 1'b1;
        step();
        man_fd = 1'b0;
        idle(2);
        chk("t4_fs_end", int'(bus.fs_read), 0);
        chk("t4_com_end", int'(bus.com_state), 2);
        chk("t4_busy_end", int'(bus.busy), 0);
        chk("t4_err_end", int'(bus.err_cnt), 1);

        // Inter-byte timeout and header resynchronisation
        do_reset();
        send_byte(8'h55);
        send_byte(8'hAA);
        idle(TO + 5);
        send_byte(8'h01);
        send_byte(8'hFE);
        idle(4);
        chk("t5_fs_timeout", int'(bus.fs_read), 0);
        chk("t5_err_timeout", int'(bus.err_cnt), 0);
        chk("t5_busy_timeout", int'(bus.busy), 0);
        send_byte(8'h55);
        send_byte(8'h55);
        send_byte(8'hAA);
        send_byte(8'h00);
        send_byte(8'hFF);
        step();
        chk("t5_fs_resync", int'(bus.fs_read), 1);
        chk("t5_com_resync", int'(bus.com_state), 0);
        man_fd = 1'b1;
        step();
        man_fd = 1'b0;
        idle(2);
        send_byte(8'h55);
        send_byte(8'hAA);
        idle(TO - 5);
        send_byte(8'h03);
        send_byte(8'hFC);
        step();
        chk("t5_fs_slow_ok", int'(bus.fs_read), 1);
        chk("t5_com_slow_ok", int'(bus.com_state), 3);
        man_fd = 1'b1;
        step();
        man_fd = 1'b0;
        idle(2);

        // Asynchronous reset during a handshake with a pending command
        do_reset();
        send_frame(8'h01, 8'hFE);
        send_frame(8'h02, 8'hFD);
        chk("t6_fs_pre", int'(bus.fs_read), 1);
        chk("t6_busy_pre", int'(bus.busy), 1);
        rst_n = 1'b0;
        #1;
        chk("t6_fs_async", int'(bus.fs_read), 0);
        chk("t6_com_async", int'(bus.com_state), 0);
        chk("t6_busy_async", int'(bus.busy), 0);
        idle(2);
        rst_n = 1'b1;
        idle(10);
        chk("t6_fs_after", int'(bus.fs_read), 0);
        chk("t6_busy_after", int'(bus.busy), 0);

        // Random frames, noise and aborted headers against the frame-level model
        exp_err   = 0;
        model_com = 2'b00;
        auto_ack  = 1'b1;
        for (int f = 0; f < 40; f++) begin
            nn = $urandom_range(0, 3);
            for (int i = 0; i < nn; i++) begin
                b = 8'($urandom);
                if (b == 8'h55) b = 8'h00;
                send_byte(b);
            end
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                send_byte(8'h55);
                send_byte(8'hAA);
                idle(TO + 3);
            end else if (kind == 1) begin
                send_byte(8'h55);
                send_byte(8'h12);
            end else begin
                repeat ($urandom_range(0, 2)) send_byte(8'h55);
                cmd  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 3));
                ck   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : ~cmd;
                good = (ck == ~cmd) && (cmd[7:2] == 6'd0);
                skip = 1'b0;
`ifdef CMD_FILTER_SAME_EN
                skip = (cmd[1:0] == 2'b11) && (model_com == 2'b11);
`endif
                if (!good) begin
                    exp_err = (exp_err < 255) ? exp_err + 1 : 255;
                end else if (!skip) begin
                    exp_q.push_back(cmd[1:0]);
                    model_com = cmd[1:0];
                end
                send_byte(8'h55);
                idle($urandom_range(0, 2));
                send_byte(8'hAA);
                idle($urandom_range(0, 2));
                send_byte(cmd);
                idle($urandom_range(0, 2));
                send_byte(ck);
            end
            wait_idle("rand_busy_clear");
        end
        idle(4);
        auto_ack = 1'b0;
        chk("rand_queue_left", exp_q.size(), 0);
        chk("rand_err_cnt", int'(bus.err_cnt), exp_err);
        chk("rand_com_last", int'(bus.com_state), int'(model_com));

        // err_cnt saturation
        do_reset();
        for (int i = 0; i < 260; i++) send_frame(8'h02, 8'h00);
        idle(2);
        chk("sat_err_cnt", int'(bus.err_cnt), 255);
        chk("sat_fs", int'(bus.fs_read), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
